// File: rtl/spy_serial.sv
// spy_serial: 8N1 UART transceiver bridging RS-232 to the spy port's four-phase rx/ld_tx handshakes.
// Define SPY_SERIAL_PARITY_EN to insert/check an even-parity bit after bit 7 on both directions.
module spy_serial #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic       tx_out,
    input  logic       rx_enable,
    input  logic       rx_req,
    output logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    input  logic       tx_enable,
    input  logic       ld_tx_req,
    output logic       ld_tx_ack,
    input  logic [7:0] tx_data,
    output logic       tx_empty,
    output logic [2:0] rx_state_dbg,
    output logic [2:0] tx_state_dbg
);
    // Handshakes: rx_ack and ld_tx_ack are registered four-phase acks; each rises one edge after
    // its request is seen with data available (rx) or the transmitter idle (tx), holds while the
    // request stays high, and falls on the edge after the request drops.
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef SPY_SERIAL_PARITY_EN
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAITHI} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
`else
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif

    logic          sync1_q, sync1_d, rx_s_q, rx_s_d;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_empty_q, rx_empty_d;
    logic          rx_ack_q, rx_ack_d;
    logic          rx_ferr_q, rx_ferr_d;
    logic          rx_ovr_q, rx_ovr_d;
    logic          rx_par_good;
    logic          rx_load, ack_rise;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_out_q, tx_out_d;
    logic          tx_empty_q, tx_empty_d;
    logic          ld_tx_ack_q, ld_tx_ack_d;
    logic          tx_load;

`ifdef SPY_SERIAL_PARITY_EN
    logic rx_par_ok_q, rx_par_ok_d;
    logic tx_par_q, tx_par_d;
    assign rx_par_good = rx_par_ok_q;
`else
    assign rx_par_good = 1'b1;
`endif

    assign sync1_d = rx_in;
    assign rx_s_d  = sync1_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_empty_d = rx_empty_q;
        rx_ovr_d   = rx_ovr_q;
        rx_ferr_d  = 1'b0;
        rx_load    = 1'b0;
`ifdef SPY_SERIAL_PARITY_EN
        rx_par_ok_d = rx_par_ok_q;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == CNT_HALF) begin
                // Mid-bit recheck rejects glitches shorter than half a bit.
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
`ifdef SPY_SERIAL_PARITY_EN
                if (rx_bit_q == 3'd7) rx_state_d = RX_PARITY;
`else
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
`endif
            end
`ifdef SPY_SERIAL_PARITY_EN
            RX_PARITY: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d    = '0;
                rx_par_ok_d = (rx_s_q == ^rx_shift_q);
                rx_state_d  = RX_STOP;
            end
`endif
            RX_STOP: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d = '0;
                if (!rx_s_q) begin
                    rx_ferr_d  = 1'b1;
                    rx_state_d = RX_WAITHI;
                end else begin
                    rx_state_d = RX_IDLE;
                    rx_load    = rx_par_good;
                    rx_ferr_d  = !rx_par_good;
                end
            end
            RX_WAITHI: if (rx_s_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
        if (!rx_enable) begin
            rx_state_d = RX_IDLE;
            rx_load    = 1'b0;
            rx_ferr_d  = 1'b0;
        end

        // A completing byte takes priority; the ack then rises a cycle later on the new byte.
        ack_rise = !rx_ack_q && rx_req && !rx_empty_q && !rx_load;
        rx_ack_d = rx_ack_q ? rx_req : ack_rise;
        if (rx_load) begin
            rx_data_d  = rx_shift_q;
            rx_empty_d = 1'b0;
            if (!rx_empty_q) rx_ovr_d = 1'b1;
        end else if (ack_rise) begin
            rx_empty_d = 1'b1;
            rx_ovr_d   = 1'b0;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        tx_empty_d = tx_empty_q;
`ifdef SPY_SERIAL_PARITY_EN
        tx_par_d = tx_par_q;
`endif
        tx_load     = ld_tx_req && tx_empty_q && tx_enable && !ld_tx_ack_q;
        ld_tx_ack_d = ld_tx_ack_q ? ld_tx_req : tx_load;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_load) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
                    tx_out_d   = 1'b0;
                    tx_empty_d = 1'b0;
`ifdef SPY_SERIAL_PARITY_EN
                    tx_par_d = ^tx_data;
`endif
                end
            end
            TX_START: if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_out_d   = tx_shift_q[0];
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 3'd7) begin
`ifdef SPY_SERIAL_PARITY_EN
                    tx_out_d   = tx_par_q;
                    tx_state_d = TX_PARITY;
`else
                    tx_out_d   = 1'b1;
                    tx_state_d = TX_STOP;
`endif
                end else begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_out_d   = tx_shift_q[1];
                    tx_bit_d   = tx_bit_q + 3'd1;
                end
            end
`ifdef SPY_SERIAL_PARITY_EN
            TX_PARITY: if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d   = '0;
                tx_out_d   = 1'b1;
                tx_state_d = TX_STOP;
            end
`endif
            TX_STOP: if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d   = '0;
                tx_empty_d = 1'b1;
                tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_empty_q  <= 1'b1;
            rx_ack_q    <= 1'b0;
            rx_ferr_q   <= 1'b0;
            rx_ovr_q    <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_out_q    <= 1'b1;
            tx_empty_q  <= 1'b1;
            ld_tx_ack_q <= 1'b0;
`ifdef SPY_SERIAL_PARITY_EN
            rx_par_ok_q <= 1'b0;
            tx_par_q    <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_empty_q  <= rx_empty_d;
            rx_ack_q    <= rx_ack_d;
            rx_ferr_q   <= rx_ferr_d;
            rx_ovr_q    <= rx_ovr_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_out_q    <= tx_out_d;
            tx_empty_q  <= tx_empty_d;
            ld_tx_ack_q <= ld_tx_ack_d;
`ifdef SPY_SERIAL_PARITY_EN
            rx_par_ok_q <= rx_par_ok_d;
            tx_par_q    <= tx_par_d;
`endif
        end
    end

    assign tx_out       = tx_out_q;
    assign rx_ack       = rx_ack_q;
    assign rx_data      = rx_data_q;
    assign rx_empty     = rx_empty_q;
    assign rx_frame_err = rx_ferr_q;
    assign rx_overrun   = rx_ovr_q;
    assign ld_tx_ack    = ld_tx_ack_q;
    assign tx_empty     = tx_empty_q;
    assign rx_state_dbg = rx_state_q;
    assign tx_state_dbg = tx_state_q;

endmodule

// File: tb/tb_spy_serial.sv
// tb_spy_serial: directed bench for spy_serial at CLKS_PER_BIT=8; received bytes go through an expected queue.
module tb_spy_serial;
    localparam int CPB = 8;
`ifdef SPY_SERIAL_PARITY_EN
    localparam int NBITS = 11;
    logic par_flip = 1'b0;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_enable = 1'b1;
    logic       rx_req = 1'b0;
    logic       tx_enable = 1'b1;
    logic       ld_tx_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_out, rx_ack, rx_empty, rx_frame_err, rx_overrun, ld_tx_ack, tx_empty;
    logic [7:0] rx_data;
    logic [2:0] rx_state_dbg, tx_state_dbg;

    int checks = 0;
    int failures = 0;
    int ferr_seen = 0;
    int ferr_base;
    logic [7:0] exp_q[$];

    spy_serial #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .tx_out(tx_out),
        .rx_enable(rx_enable), .rx_req(rx_req), .rx_ack(rx_ack), .rx_data(rx_data),
        .rx_empty(rx_empty), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
        .tx_enable(tx_enable), .ld_tx_req(ld_tx_req), .ld_tx_ack(ld_tx_ack),
        .tx_data(tx_data), .tx_empty(tx_empty),
        .rx_state_dbg(rx_state_dbg), .tx_state_dbg(tx_state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) if (rx_frame_err) ferr_seen <= ferr_seen + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame on rx_in starting at a negedge; leaves the line high afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            tick(CPB);
        end
`ifdef SPY_SERIAL_PARITY_EN
        rx_in = (^b) ^ par_flip;
        tick(CPB);
`endif
        rx_in = stop_bit;
        tick(CPB);
        rx_in = 1'b1;
    endtask

    task automatic expect_byte(input string tag);
        logic [7:0] exp;
        for (int i = 0; i < 2 * CPB && rx_empty; i++) tick(1);
        check({tag, "_empty"}, rx_empty, 1'b0);
        exp = exp_q.pop_front();
        check({tag, "_data"}, rx_data, exp);
    endtask

    task automatic read_byte(input string tag);
        rx_req = 1'b1;
        tick(1);
        check({tag, "_ack_rise"}, rx_ack, 1'b1);
        check({tag, "_empty_set"}, rx_empty, 1'b1);
        check({tag, "_ovr_clr"}, rx_overrun, 1'b0);
        rx_req = 1'b0;
        tick(1);
        check({tag, "_ack_fall"}, rx_ack, 1'b0);
    endtask

    // Loads b and checks every bit mid-cell, the ack timing and the tx_empty return edge.
    task automatic tx_check(input logic [7:0] b);
        logic [10:0] bits;
        bits = 11'h7ff;
        bits[0] = 1'b0;
        bits[8:1] = b;
`ifdef SPY_SERIAL_PARITY_EN
        bits[9] = ^b;
`endif
        tx_data = b;
        ld_tx_req = 1'b1;
        tick(1);
        check("tx_ack_rise", ld_tx_ack, 1'b1);
        check("tx_empty_clr", tx_empty, 1'b0);
        ld_tx_req = 1'b0;
        for (int n = 2; n <= NBITS * CPB + 1; n++) begin
            tick(1);
            if (n == 2) check("tx_ack_fall", ld_tx_ack, 1'b0);
            if (n % CPB == CPB / 2) check($sformatf("tx_bit%0d", n / CPB), tx_out, bits[n / CPB]);
            if (n == NBITS * CPB) check("tx_empty_before_end", tx_empty, 1'b0);
        end
        check("tx_empty_at_end", tx_empty, 1'b1);
    endtask

    initial begin
        tick(3);
        check("rst_tx_out", tx_out, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_empty", rx_empty, 1'b1);
        check("rst_rx_ack", rx_ack, 1'b0);
        check("rst_ferr", rx_frame_err, 1'b0);
        check("rst_ovr", rx_overrun, 1'b0);
        check("rst_ld_ack", ld_tx_ack, 1'b0);
        check("rst_tx_empty", tx_empty, 1'b1);
        reset = 1'b0;
        tick(4);

        // Basic receive and read handshake.
        exp_q.push_back(8'h83);
        send_frame(8'h83, 1'b1);
        expect_byte("rx83");
        read_byte("rd83");

        // Transmit 0x35.
        tx_check(8'h35);

        // Loads are blocked while tx_enable is low.
        tx_enable = 1'b0;
        tx_data = 8'hAA;
        ld_tx_req = 1'b1;
        tick(3);
        check("tx_dis_ack", ld_tx_ack, 1'b0);
        check("tx_dis_empty", tx_empty, 1'b1);
        ld_tx_req = 1'b0;
        tx_enable = 1'b1;
        tick(2);

        // Overrun: second byte overwrites the unread first one.
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1);
        expect_byte("rx41");
        check("ovr_first", rx_overrun, 1'b0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        expect_byte("rx42");
        check("ovr_set", rx_overrun, 1'b1);
        read_byte("rd42");

        // Framing error with the line held low afterwards.
        ferr_base = ferr_seen;
        send_frame(8'h55, 1'b0);
        rx_in = 1'b0;
        tick(3 * CPB);
        check("ferr_pulse_count", ferr_seen - ferr_base, 1);
        check("ferr_empty", rx_empty, 1'b1);
        rx_in = 1'b1;
        tick(2 * CPB);
        check("ferr_after_high", ferr_seen - ferr_base, 1);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        expect_byte("rxA5");
        read_byte("rdA5");

        // Glitch shorter than half a bit.
        ferr_base = ferr_seen;
        rx_in = 1'b0;
        tick(2);
        rx_in = 1'b1;
        tick(12 * CPB);
        check("glitch_empty", rx_empty, 1'b1);
        check("glitch_ferr", ferr_seen - ferr_base, 0);

        // Receiver disabled: frame ignored.
        rx_enable = 1'b0;
        send_frame(8'h11, 1'b1);
        tick(2);
        check("rx_dis_empty", rx_empty, 1'b1);
        rx_enable = 1'b1;
        tick(2);

`ifdef SPY_SERIAL_PARITY_EN
        tx_check(8'h07);
        ferr_base = ferr_seen;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        tick(2);
        check("par_ferr", ferr_seen - ferr_base, 1);
        check("par_empty", rx_empty, 1'b1);
`endif

        // Reset in the middle of a transmit frame.
        tx_data = 8'h00;
        ld_tx_req = 1'b1;
        tick(1);
        ld_tx_req = 1'b0;
        tick(20);
        check("midtx_busy", tx_empty, 1'b0);
        check("midtx_low", tx_out, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_mid_tx_out", tx_out, 1'b1);
        check("rst_mid_tx_empty", tx_empty, 1'b1);
        tick(2);
        reset = 1'b0;
        tick(2);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spy_serial.md
# spy_serial

Byte-serial transceiver feeding the spy port's command decoder and carrying its hex-nibble responses back out on the RS-232 line. It converts asynchronous 8N1 serial traffic on `rs232_rxd`/`rs232_txd` into single-byte four-phase req/ack transfers, receive side and transmit side. It is a drop-in peer for the spy port's existing `rx_req`/`rx_ack` and `ld_tx_req`/`ld_tx_ack` protocol.

## Interface
- `CLKS_PER_BIT`, 434: clocks per serial bit (50 MHz / 115200); legal range ≥ 4.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_in`  in  1  serial receive line, asynchronous, idle high.
- `tx_out`  out  1  serial transmit line, idle high.
- `rx_enable`  in  1  receiver enable.
- `rx_req`  in  1  consumer request for the buffered byte.
- `rx_ack`  out  1  receive acknowledge.
- `rx_data`  out  8  buffered received byte.
- `rx_empty`  out  1  1 = no unread byte buffered.
- `rx_frame_err`  out  1  one-cycle pulse: bad stop bit, or bad parity when parity is compiled in.
- `rx_overrun`  out  1  sticky flag: an unread byte was overwritten.
- `tx_enable`  in  1  transmitter enable.
- `ld_tx_req`  in  1  producer request to load `tx_data`.
- `ld_tx_ack`  out  1  load acknowledge.
- `tx_data`  in  8  byte to send.
- `tx_empty`  out  1  1 = transmitter idle and able to accept a load.

## Operation
- Reset values: `tx_out`=1, `rx_data`=0, `rx_empty`=1, `rx_ack`=0, `rx_frame_err`=0, `rx_overrun`=0, `ld_tx_ack`=0, `tx_empty`=1. Both state machines go to IDLE and the synchronizer flops go to 1.
- Reset asserted mid-frame aborts the frame with no partial byte delivered. `tx_out` goes to 1 immediately.
- Receive path: `rx_in` passes through a 2-flop synchronizer.
- RX FSM states: IDLE, START, DATA, (PARITY), STOP, WAITHI.
  - IDLE → START on a synchronized low.
  - In START, the line is sampled at `CLKS_PER_BIT/2`. Low → DATA. High → IDLE (false start).
  - DATA samples 8 bits, LSB first, every `CLKS_PER_BIT` cycles.
  - STOP sample = 1 → load `rx_data`, clear `rx_empty`, return to IDLE.
  - STOP sample = 0 → pulse `rx_frame_err`, discard the byte, go to WAITHI. WAITHI returns to IDLE once the line is high.
- `rx_enable`=0 forces the RX FSM to IDLE and discards any frame in progress. The buffered byte is kept.
- Overrun: a good byte arriving while `rx_empty`=0 overwrites `rx_data` and sets `rx_overrun`. `rx_overrun` clears on the next `rx_ack` rise.
- RX handshake (four-phase):
  - Rise: `rx_ack` rises on the edge after `rx_req`=1 && `rx_empty`=0 && `rx_ack`=0. On that same edge `rx_empty` is set.
  - Hold: `rx_ack` stays 1 while `rx_req`=1.
  - Fall: `rx_ack` falls on the edge after `rx_req`=0.
  - `rx_data` is stable from the request through the ack rise.
- Simultaneous events: if a stop-bit load coincides with a pending ack rise, the load wins and the ack rises one cycle later, acknowledging the new byte.
- Receive with `rx_ack`=1: a byte completing while `rx_ack` is still high loads normally and leaves `rx_empty`=0.
- TX handshake (four-phase):
  - Load: on an edge with `ld_tx_req`=1 && `tx_empty`=1 && `tx_enable`=1 && `ld_tx_ack`=0, the block captures `tx_data`, sets `ld_tx_ack`=1, and clears `tx_empty`.
  - Hold/fall: `ld_tx_ack` holds while `ld_tx_req`=1 and falls on the edge after `ld_tx_req`=0.
  - No second load occurs until the ack has dropped.
- TX FSM states: IDLE, START, DATA, (PARITY), STOP. Each bit lasts exactly `CLKS_PER_BIT` cycles. `tx_empty` sets at the end of the stop bit.
- `tx_enable`=0 blocks new loads only. A frame already in progress completes.

## Timing
- TX: the start bit drives `tx_out` from the load edge. `tx_empty` returns to 1 exactly 10·`CLKS_PER_BIT` cycles after the load edge (11 with parity).
- RX: `rx_empty` falls 2 synchronizer cycles + 9.5·`CLKS_PER_BIT` (±1) after the start-bit falling edge on `rx_in`. Add 1·`CLKS_PER_BIT` with parity.
- Handshake acks are registered: one cycle of latency from request edge to ack edge.
- Bit counters are sized `$clog2(CLKS_PER_BIT)`. The half-bit point is `CLKS_PER_BIT/2`, truncated.

## Configuration
- `SPY_SERIAL_PARITY_EN` defined: an even-parity bit is inserted after bit 7 on TX and checked on RX. A parity mismatch pulses `rx_frame_err` and discards the byte; the stop bit is still checked.
- Not defined: plain 8N1, with no PARITY states.

## Test plan
All scenarios use `CLKS_PER_BIT`=8.
- Drive 8N1 frame 0x83 on `rx_in`. Required: `rx_empty` falls with `rx_data`=0x83. Then assert `rx_req`: `rx_ack` rises 1 cycle later and `rx_empty`=1. Drop `rx_req`: `rx_ack` falls 1 cycle later.
- Load 0x35. Required: `tx_out` carries 0,1,0,1,0,1,1,0,0,1, each bit 8 cycles. `ld_tx_ack` rises on the load edge. `tx_empty` returns to 1 exactly 80 cycles after the load edge.
- Drive 0x41 then 0x42 with no read in between. Required: `rx_data`=0x42 and `rx_overrun`=1. `rx_overrun` clears on the next ack.
- Drive 0x55 with stop bit = 0. Required: `rx_frame_err` pulses for 1 cycle, `rx_empty` stays 1, and no byte is accepted until the line returns high.
- Pulse `rx_in` low for 2 cycles (glitch). Required: no byte, no error. Assert `reset` mid-TX-frame: `tx_out`=1 and `tx_empty`=1 immediately.
- With `SPY_SERIAL_PARITY_EN`: load 0x07. Required: parity bit 1, frame length 88 cycles. Received 0x07 with parity bit 0 → `rx_frame_err` pulse.
